// File: rtl/cfg_reg_bank_arb_pkg.sv
// Shared types and address-map decode for the configuration register bank.
package cfg_reg_bank_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    MAP_RW,
    MAP_STS,
    MAP_ID,
    MAP_NONE
  } map_kind_t;

  localparam int unsigned STS_STARVE_BIT = 7;

  function automatic map_kind_t decode_addr(
    input logic [7:0]  addr,
    input int unsigned num_regs,
    input logic [7:0]  sts_addr,
    input logic [7:0]  id_addr
  );
    if (32'(addr) < num_regs) return MAP_RW;
    if (addr == sts_addr)     return MAP_STS;
    if (addr == id_addr)      return MAP_ID;
    return MAP_NONE;
  endfunction

endpackage

// File: rtl/cfg_reg_bank_arb_if.sv
// Host (I2C slave) register port and internal req/gnt port of the register bank.
interface cfg_reg_bank_arb_if;

  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_wr_en;
  logic       host_rd_en;
  logic [7:0] host_rdata;

  logic       int_req;
  logic       int_we;
  logic [7:0] int_addr;
  logic [7:0] int_wdata;
  logic       int_gnt;
  logic       int_rvalid;
  logic [7:0] int_rdata;
  logic       int_err;

  modport slave (
    input  host_addr, host_wdata, host_wr_en, host_rd_en,
    output host_rdata,
    input  int_req, int_we, int_addr, int_wdata,
    output int_gnt, int_rvalid, int_rdata, int_err
  );

  modport master (
    output host_addr, host_wdata, host_wr_en, host_rd_en,
    input  host_rdata,
    output int_req, int_we, int_addr, int_wdata,
    input  int_gnt, int_rvalid, int_rdata, int_err
  );

endinterface

// File: rtl/cfg_reg_bank_arb_sts.sv
// Sticky status byte: per-bit set, clear-on-read of only the bits the reader actually saw.
module sts_sticky_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] set_i,
  input  logic       clr_i,
  output logic [7:0] q_o
);

  logic [7:0] sts_q, sts_d;
  logic [7:0] snap_q;

  // snap_q is what the reader sampled last cycle; bits set since then survive the clear
  always_comb begin
    sts_d = sts_q | set_i;
    if (clr_i) sts_d = (sts_q & ~snap_q) | set_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_q  <= '0;
      snap_q <= '0;
    end else begin
      sts_q  <= sts_d;
      snap_q <= sts_q;
    end
  end

  assign q_o = sts_q;

endmodule

// File: rtl/cfg_reg_bank_arb.sv
// Config register bank: host port has absolute priority, internal requester arbitrated via req/gnt.
module cfg_reg_bank_arb
  import cfg_reg_bank_arb_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [7:0]  STS_ADDR  = 8'h10,
  parameter logic [7:0]  ID_ADDR   = 8'hFF,
  parameter logic [7:0]  ID_VALUE  = 8'hC5,
  parameter int unsigned MAX_DEFER = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cfg_reg_bank_arb_if.slave     bus,
  input  logic [7:0]            sts_set,
  output logic [8*NUM_REGS-1:0] cfg_regs
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned DW    = $clog2(MAX_DEFER + 1);

  arb_state_t       state_q, state_d;
  logic [DW-1:0]    defer_q, defer_d;
  logic             gnt;
  logic             starve;
  logic             host_busy;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       sts_q;
  logic [7:0]       sts_set_all;
  map_kind_t        host_kind, int_kind;
  logic [IDX_W-1:0] host_idx, int_idx;
  logic [7:0]       int_rd_mux;
  logic             int_err_c;
  logic             rvalid_q, err_q;
  logic [7:0]       rdata_q;

  assign host_busy = bus.host_wr_en | bus.host_rd_en;
  assign host_idx  = bus.host_addr[IDX_W-1:0];
  assign int_idx   = bus.int_addr[IDX_W-1:0];

  always_comb begin
    host_kind = decode_addr(bus.host_addr, NUM_REGS, STS_ADDR, ID_ADDR);
    int_kind  = decode_addr(bus.int_addr, NUM_REGS, STS_ADDR, ID_ADDR);
  end

  always_comb begin
    bus.host_rdata = '0;
    case (host_kind)
      MAP_RW:  bus.host_rdata = regs_q[host_idx];
      MAP_STS: bus.host_rdata = sts_q;
      MAP_ID:  bus.host_rdata = ID_VALUE;
      default: bus.host_rdata = '0;
    endcase
  end

  always_comb begin
    int_rd_mux = '0;
    case (int_kind)
      MAP_RW:  int_rd_mux = regs_q[int_idx];
      MAP_STS: int_rd_mux = sts_q;
      MAP_ID:  int_rd_mux = ID_VALUE;
      default: int_rd_mux = '0;
    endcase
    int_err_c = bus.int_we ? (int_kind != MAP_RW) : (int_kind == MAP_NONE);
  end

  // Any host strobe defers the internal access, so host and internal writes never collide
  always_comb begin
    state_d = state_q;
    defer_d = defer_q;
    gnt     = 1'b0;
    starve  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.int_req) state_d = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (host_busy) begin
          if (defer_q != DW'(MAX_DEFER)) begin
            defer_d = defer_q + DW'(1);
            starve  = (defer_d == DW'(MAX_DEFER));
          end
        end else begin
          gnt     = 1'b1;
          defer_d = '0;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      defer_q <= '0;
    end else begin
      state_q <= state_d;
      defer_q <= defer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & int_err_c;
      if (gnt) rdata_q <= bus.int_we ? '0 : int_rd_mux;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (bus.host_wr_en && host_kind == MAP_RW) regs_q[host_idx] <= bus.host_wdata;
      if (gnt && bus.int_we && int_kind == MAP_RW) regs_q[int_idx] <= bus.int_wdata;
    end
  end

  always_comb begin
    sts_set_all = sts_set;
    sts_set_all[STS_STARVE_BIT] = sts_set[STS_STARVE_BIT] | starve;
  end

  sts_sticky_reg u_sts (
    .clk   (clk),
    .rst_n (rst_n),
    .set_i (sts_set_all),
    .clr_i (bus.host_rd_en && host_kind == MAP_STS),
    .q_o   (sts_q)
  );

  always_comb begin
    cfg_regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) cfg_regs[8*i +: 8] = regs_q[i];
  end

  assign bus.int_gnt    = gnt;
  assign bus.int_rvalid = rvalid_q;
  assign bus.int_rdata  = rdata_q;
  assign bus.int_err    = err_q;

endmodule

// File: tb/tb_cfg_reg_bank_arb.sv
// Bench for cfg_reg_bank_arb: directed scenarios plus random host/internal traffic vs. a reference model.
module tb_cfg_reg_bank_arb;

  localparam int unsigned NR = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [7:0]    sts_set = '0;
  logic [8*NR-1:0] cfg_regs;

  cfg_reg_bank_arb_if ifc ();

  cfg_reg_bank_arb #(
    .NUM_REGS (16),
    .STS_ADDR (8'h10),
    .ID_ADDR  (8'hFF),
    .ID_VALUE (8'hC5),
    .MAX_DEFER(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .sts_set (sts_set),
    .cfg_regs(cfg_regs)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: register contents, status byte, and the internal transaction in flight
  logic [7:0] m_regs [NR];
  logic [7:0] m_sts, m_seen;
  bit         m_wait, m_rsp;
  int         m_defer;
  bit         e_rvalid, e_err;
  logic [7:0] e_rdata;

  function automatic logic [7:0] m_map(input logic [7:0] a);
    if (a < 8'd16)   return m_regs[a[3:0]];
    if (a == 8'h10)  return m_sts;
    if (a == 8'hFF)  return 8'hC5;
    return 8'h00;
  endfunction

  function automatic logic [8*NR-1:0] m_pack();
    logic [8*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
    m_sts = 8'h00; m_seen = 8'h00;
    m_wait = 0; m_rsp = 0; m_defer = 0;
    e_rvalid = 0; e_err = 0; e_rdata = 8'h00;
  endtask

  // Advance one clock edge and apply to the model what the inputs present at that edge imply
  task automatic tick();
    bit hs, g, starve, nw;
    logic [7:0] nsts;
    @(posedge clk);
    hs = ifc.host_wr_en || ifc.host_rd_en;
    g = m_wait && !hs;
    starve = 1'b0;
    if (g) begin
      e_rdata = ifc.int_we ? 8'h00 : m_map(ifc.int_addr);
      e_err = ifc.int_we ? (ifc.int_addr >= 8'd16)
                         : !(ifc.int_addr < 8'd16 || ifc.int_addr == 8'h10 || ifc.int_addr == 8'hFF);
      m_defer = 0;
      if (ifc.int_we && ifc.int_addr < 8'd16) m_regs[ifc.int_addr[3:0]] = ifc.int_wdata;
    end else if (m_wait && m_defer < 8) begin
      m_defer++;
      starve = (m_defer == 8);
    end
    e_rvalid = g;
    if (ifc.host_wr_en && ifc.host_addr < 8'd16) m_regs[ifc.host_addr[3:0]] = ifc.host_wdata;
    nsts = (ifc.host_rd_en && ifc.host_addr == 8'h10) ? (m_sts & ~m_seen) : m_sts;
    nsts = nsts | sts_set | {starve, 7'b0};
    m_seen = m_sts;
    m_sts = nsts;
    nw = m_wait ? !g : (!m_rsp && ifc.int_req);
    m_rsp = g;
    m_wait = nw;
    #1;
  endtask

  // Requester driver: returns the cycle of int_gnt (-1 if none) and the response-cycle outputs
  task automatic int_txn(input bit we, input logic [7:0] a, input logic [7:0] d,
                         input int n_strobe, input logic [7:0] hw_a,
                         output int gnt_cyc, output logic rv, output logic [7:0] rd, output logic er);
    ifc.int_req = 1'b1; ifc.int_we = we; ifc.int_addr = a; ifc.int_wdata = d;
    gnt_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      ifc.host_wr_en = (c < n_strobe);
      ifc.host_addr  = hw_a;
      ifc.host_wdata = 8'(c + 8'h40);
      #2;
      if (ifc.int_gnt === 1'b1) gnt_cyc = c;
      tick();
      if (gnt_cyc >= 0) break;
    end
    ifc.int_req = 1'b0; ifc.host_wr_en = 1'b0;
    #2;
    rv = ifc.int_rvalid; rd = ifc.int_rdata; er = ifc.int_err;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] ha [8] = '{8'h00, 8'h03, 8'h0F, 8'h10, 8'hFF, 8'h20, 8'h11, 8'h80};
    logic [7:0] he [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC5, 8'h00, 8'h00, 8'h00};
    logic [7:0] ia [6] = '{8'h00, 8'h07, 8'h0F, 8'h10, 8'hFF, 8'h20};
    logic [7:0] ie [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC5, 8'h00};
    logic       ee [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int g; logic rv, er; logic [7:0] rd;
    repeat (2) @(posedge clk);
    #3;
    n_tests++; if (ifc.int_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", ifc.int_gnt); end
    n_tests++; if (ifc.int_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", ifc.int_rvalid); end
    n_tests++; if (ifc.int_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", ifc.int_rdata); end
    n_tests++; if (ifc.int_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", ifc.int_err); end
    n_tests++; if (cfg_regs !== '0) begin n_fail++; $display("FAIL rst_cfg_regs: got %h want 0", cfg_regs); end
    rst_n = 1'b1;
    m_reset();
    tick();
    for (int i = 0; i < 8; i++) begin
      ifc.host_addr = ha[i];
      #1;
      n_tests++;
      if (ifc.host_rdata !== he[i]) begin
        n_fail++; $display("FAIL rst_host_rd[%h]: got %h want %h", ha[i], ifc.host_rdata, he[i]);
      end
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      int_txn(1'b0, ia[i], 8'h00, 0, 8'h00, g, rv, rd, er);
      n_tests++; if (g != 1) begin n_fail++; $display("FAIL rst_int_gnt[%h]: got cycle %0d want 1", ia[i], g); end
      n_tests++; if (rv !== 1'b1) begin n_fail++; $display("FAIL rst_int_rvalid[%h]: got %b want 1", ia[i], rv); end
      n_tests++; if (rd !== ie[i]) begin n_fail++; $display("FAIL rst_int_rdata[%h]: got %h want %h", ia[i], rd, ie[i]); end
      n_tests++; if (er !== ee[i]) begin n_fail++; $display("FAIL rst_int_err[%h]: got %b want %b", ia[i], er, ee[i]); end
    end
  endtask

  task automatic test_host_wr_int_rd();
    int g; logic rv, er; logic [7:0] rd;
    ifc.host_addr = 8'h03; ifc.host_wdata = 8'hA5; ifc.host_wr_en = 1'b1;
    tick();
    ifc.host_wr_en = 1'b0;
    #2;
    n_tests++; if (cfg_regs[31:24] !== 8'hA5) begin n_fail++; $display("FAIL host_wr_cfg3: got %h want a5", cfg_regs[31:24]); end
    tick();
    int_txn(1'b0, 8'h03, 8'h00, 0, 8'h00, g, rv, rd, er);
    n_tests++; if (g != 1) begin n_fail++; $display("FAIL hwr_int_gnt: got cycle %0d want 1", g); end
    n_tests++; if (rv !== 1'b1) begin n_fail++; $display("FAIL hwr_int_rvalid: got %b want 1", rv); end
    n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL hwr_int_rdata: got %h want a5", rd); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL hwr_int_err: got %b want 0", er); end
  endtask

  task automatic test_starvation();
    int g; logic rv, er; logic [7:0] rd;
    // 8 strobes -> 7 deferrals: below the starvation threshold
    int_txn(1'b0, 8'h05, 8'h00, 8, 8'h01, g, rv, rd, er);
    n_tests++; if (g != 8) begin n_fail++; $display("FAIL defer7_gnt: got cycle %0d want 8", g); end
    ifc.host_addr = 8'h10;
    #2;
    n_tests++; if (ifc.host_rdata[7] !== 1'b0) begin n_fail++; $display("FAIL defer7_sts7: got %b want 0", ifc.host_rdata[7]); end
    tick();
    int_txn(1'b1, 8'h05, 8'h3C, 10, 8'h01, g, rv, rd, er);
    n_tests++; if (g != 10) begin n_fail++; $display("FAIL starve_gnt: got cycle %0d want 10", g); end
    n_tests++; if (rv !== 1'b1 || rd !== 8'h00 || er !== 1'b0) begin
      n_fail++; $display("FAIL starve_resp: got rv=%b rd=%h err=%b want 1/00/0", rv, rd, er);
    end
    ifc.host_addr = 8'h10;
    #2;
    n_tests++; if (ifc.host_rdata[7] !== 1'b1) begin n_fail++; $display("FAIL starve_sts7: got %b want 1", ifc.host_rdata[7]); end
    n_tests++; if (cfg_regs[47:40] !== 8'h3C) begin n_fail++; $display("FAIL starve_cfg5: got %h want 3c", cfg_regs[47:40]); end
    n_tests++; if (cfg_regs[15:8] !== 8'h49) begin n_fail++; $display("FAIL starve_cfg1: got %h want 49", cfg_regs[15:8]); end
    tick();
  endtask

  task automatic test_sts_clear();
    ifc.host_addr = 8'h10; ifc.host_rd_en = 1'b1;
    tick();
    ifc.host_rd_en = 1'b0;
    #2;
    n_tests++; if (ifc.host_rdata !== 8'h00) begin n_fail++; $display("FAIL sts_clr_all: got %h want 00", ifc.host_rdata); end
    tick();
    sts_set = 8'h01;
    tick();
    sts_set = 8'h00;
    #2;
    n_tests++; if (ifc.host_rdata !== 8'h01) begin n_fail++; $display("FAIL sts_set1: got %h want 01", ifc.host_rdata); end
    tick();
    ifc.host_rd_en = 1'b1; sts_set = 8'h02;
    #2;
    n_tests++; if (ifc.host_rdata !== 8'h01) begin n_fail++; $display("FAIL sts_rd_cycle: got %h want 01", ifc.host_rdata); end
    tick();
    ifc.host_rd_en = 1'b0; sts_set = 8'h00;
    #2;
    n_tests++; if (ifc.host_rdata !== 8'h02) begin n_fail++; $display("FAIL sts_set_wins: got %h want 02", ifc.host_rdata); end
    tick();
    #2;
    n_tests++; if (ifc.host_rdata !== 8'h02) begin n_fail++; $display("FAIL sts_sticky: got %h want 02", ifc.host_rdata); end
    tick();
  endtask

  task automatic test_int_ro();
    int g; logic rv, er; logic [7:0] rd;
    ifc.host_addr = 8'h10; ifc.host_rd_en = 1'b1;
    tick();
    ifc.host_rd_en = 1'b0; sts_set = 8'h04;
    tick();
    sts_set = 8'h00;
    int_txn(1'b1, 8'hFF, 8'h5A, 0, 8'h00, g, rv, rd, er);
    n_tests++; if (g != 1) begin n_fail++; $display("FAIL id_wr_gnt: got cycle %0d want 1", g); end
    n_tests++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 8'h00) begin
      n_fail++; $display("FAIL id_wr_resp: got rv=%b err=%b rd=%h want 1/1/00", rv, er, rd);
    end
    ifc.host_addr = 8'hFF;
    #2;
    n_tests++; if (ifc.host_rdata !== 8'hC5) begin n_fail++; $display("FAIL id_kept: got %h want c5", ifc.host_rdata); end
    tick();
    int_txn(1'b0, 8'h10, 8'h00, 0, 8'h00, g, rv, rd, er);
    n_tests++; if (rd !== 8'h04 || er !== 1'b0) begin
      n_fail++; $display("FAIL int_rd_sts: got rd=%h err=%b want 04/0", rd, er);
    end
    ifc.host_addr = 8'h10;
    #2;
    n_tests++; if (ifc.host_rdata !== 8'h04) begin n_fail++; $display("FAIL int_rd_no_clr: got %h want 04", ifc.host_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    int g; logic rv, er; logic [7:0] rd;
    ifc.int_req = 1'b1; ifc.int_we = 1'b0; ifc.int_addr = 8'h01;
    for (int c = 0; c < 3; c++) begin
      ifc.host_wr_en = 1'b1; ifc.host_addr = 8'h01; ifc.host_wdata = 8'h77;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (ifc.int_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt: got %b want 0", ifc.int_gnt); end
    n_tests++; if (ifc.int_rdata !== 8'h00 || ifc.int_rvalid !== 1'b0 || ifc.int_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_resp: got rd=%h rv=%b err=%b want 00/0/0", ifc.int_rdata, ifc.int_rvalid, ifc.int_err);
    end
    n_tests++; if (cfg_regs !== '0) begin n_fail++; $display("FAIL rmid_cfg: got %h want 0", cfg_regs); end
    ifc.host_wr_en = 1'b0;
    @(posedge clk);
    #3;
    n_tests++; if (ifc.int_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt_held: got %b want 0", ifc.int_gnt); end
    ifc.int_req = 1'b0;
    m_reset();
    rst_n = 1'b1;
    tick();
    int_txn(1'b0, 8'h01, 8'h00, 0, 8'h00, g, rv, rd, er);
    n_tests++; if (g != 1) begin n_fail++; $display("FAIL rmid_rereq_gnt: got cycle %0d want 1", g); end
    n_tests++; if (rv !== 1'b1 || rd !== 8'h00) begin n_fail++; $display("FAIL rmid_rereq_rd: got rv=%b rd=%h want 1/00", rv, rd); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    bit hs;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0, 1:    begin ifc.host_wr_en = 1'b1; ifc.host_rd_en = 1'b0; end
        2, 3:    begin ifc.host_wr_en = 1'b0; ifc.host_rd_en = 1'b1; end
        default: begin ifc.host_wr_en = 1'b0; ifc.host_rd_en = 1'b0; end
      endcase
      case ($urandom_range(0, 3))
        0, 1:    a = {4'h0, 4'($urandom)};
        2:       a = 8'h10;
        default: a = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
      endcase
      ifc.host_addr  = a;
      ifc.host_wdata = 8'($urandom);
      sts_set = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if (m_rsp) ifc.int_req = 1'b0;
      else if (!ifc.int_req && $urandom_range(0, 2) == 0) begin
        ifc.int_req   = 1'b1;
        ifc.int_we    = 1'($urandom);
        ifc.int_addr  = $urandom_range(0, 2) != 0 ? {4'h0, 4'($urandom)}
                                                  : ($urandom_range(0, 1) ? 8'h10 : 8'($urandom));
        ifc.int_wdata = 8'($urandom);
      end
      hs = ifc.host_wr_en || ifc.host_rd_en;
      #2;
      n_tests++; if (ifc.host_rdata !== m_map(ifc.host_addr)) begin
        n_fail++; $display("FAIL rnd_host_rdata c%0d a=%h: got %h want %h", c, ifc.host_addr, ifc.host_rdata, m_map(ifc.host_addr));
      end
      n_tests++; if (ifc.int_gnt !== (m_wait && !hs)) begin
        n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, ifc.int_gnt, m_wait && !hs);
      end
      n_tests++; if (ifc.int_rvalid !== e_rvalid) begin
        n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, ifc.int_rvalid, e_rvalid);
      end
      n_tests++; if (ifc.int_rdata !== e_rdata) begin
        n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, ifc.int_rdata, e_rdata);
      end
      n_tests++; if (ifc.int_err !== (e_rvalid && e_err)) begin
        n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, ifc.int_err, e_rvalid && e_err);
      end
      n_tests++; if (cfg_regs !== m_pack()) begin
        n_fail++; $display("FAIL rnd_cfg_regs c%0d: got %h want %h", c, cfg_regs, m_pack());
      end
      tick();
    end
    ifc.host_wr_en = 1'b0; ifc.host_rd_en = 1'b0; ifc.int_req = 1'b0; sts_set = 8'h00;
    repeat (3) tick();
  endtask

  initial begin
    ifc.host_addr = '0; ifc.host_wdata = '0; ifc.host_wr_en = 1'b0; ifc.host_rd_en = 1'b0;
    ifc.int_req = 1'b0; ifc.int_we = 1'b0; ifc.int_addr = '0; ifc.int_wdata = '0;
    m_reset();
    test_reset();
    test_host_wr_int_rd();
    test_starvation();
    test_sts_clear();
    test_int_ro();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_tests);
    $fatal(1, "time limit");
  end

endmodule
